// File: rtl/regb_fifo_lvl.sv
// regb_fifo_lvl: register-based FIFO of arbitrary depth with fill level,
// programmable almost-full/almost-empty flags, sticky overflow/underflow
// error flags, and a choice of first-word-fall-through or registered read.
module regb_fifo_lvl #(
    parameter int WIDTH  = 16,
    parameter int N      = 5,
    parameter int AF_THR = 4,
    parameter int AE_THR = 1,
    parameter int FWFT   = 1,
    localparam int CW    = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             shift_in,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             shift_out,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    level,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    // Pointer width: enough to address words 0..N-1.
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    // Refuse to elaborate with a depth or threshold set that makes no sense.
    generate
        if (N < 2 || AE_THR < 0 || AE_THR >= AF_THR || AF_THR > N) begin : g_param_err
            $error("regb_fifo_lvl: need N>=2 and 0 <= AE_THR < AF_THR <= N");
        end
    endgenerate

    logic [WIDTH-1:0] mem [N];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    level_reg;
    logic [CW-1:0]    level_next;
    logic             overflow_reg;
    logic             underflow_reg;
    logic             full_int;
    logic             empty_int;
    logic             wr_en;
    logic             rd_en;

    // Pointer advance with wrap at N-1, so depth need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    // Status flags come only from the registered level: no input-to-flag path.
    assign full_int     = (level_reg == CW'(N));
    assign empty_int    = (level_reg == '0);
    assign full         = full_int;
    assign empty        = empty_int;
    assign almost_full  = (level_reg >= CW'(AF_THR));
    assign almost_empty = (level_reg <= CW'(AE_THR));
    assign level        = level_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A write at full or a read at empty is simply refused; there is no
    // same-cycle bypass from wdata to rdata.
    assign wr_en = shift_in && !full_int;
    assign rd_en = shift_out && !empty_int;

    // Level moves by one only when exactly one side is accepted.
    always_comb begin
        level_next = level_reg;
        case ({wr_en, rd_en})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // Storage words: each register loads only when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_word
            always_ff @(posedge clk or posedge res) begin
                if (res) begin
                    mem[gi] <= '0;
                end else if (wr_en && (wr_ptr_reg == PW'(gi))) begin
                    mem[gi] <= wdata;
                end
            end
        end
    endgenerate

    // Pointers and level register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (rd_en) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            level_reg <= level_next;
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err wins.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            overflow_reg  <= (overflow_reg && !clr_err) || (shift_in && full_int);
            underflow_reg <= (underflow_reg && !clr_err) || (shift_out && empty_int);
        end
    end

    // Read port: either the head word straight from storage, or a word
    // captured on the read edge with a one-cycle valid pulse.
    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata  = mem[rd_ptr_reg];
            assign rvalid = !empty_int;
        end else begin : g_regrd
            logic [WIDTH-1:0] rdata_reg;
            logic             rvalid_reg;

            // Capture the head word on an accepted read; hold it otherwise.
            always_ff @(posedge clk or posedge res) begin
                if (res) begin
                    rdata_reg  <= '0;
                    rvalid_reg <= 1'b0;
                end else begin
                    rvalid_reg <= rd_en;
                    if (rd_en) begin
                        rdata_reg <= mem[rd_ptr_reg];
                    end
                end
            end

            assign rdata  = rdata_reg;
            assign rvalid = rvalid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_regb_fifo_lvl.sv
// tb_regb_fifo_lvl: drives one FWFT and one registered-read FIFO with the same
// stimulus and checks both against a queue-based model every cycle.
module tb_regb_fifo_lvl;

    localparam int WIDTH  = 16;
    localparam int N      = 5;
    localparam int AF_THR = 4;
    localparam int AE_THR = 1;
    localparam int CW     = $clog2(N + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             res       = 1'b0;
    logic             shift_in  = 1'b0;
    logic             shift_out = 1'b0;
    logic             clr_err   = 1'b0;
    logic [WIDTH-1:0] wdata     = '0;

    logic             full_f, rvalid_f, empty_f, af_f, ae_f, ovf_f, unf_f;
    logic [WIDTH-1:0] rdata_f;
    logic [CW-1:0]    level_f;
    logic             full_r, rvalid_r, empty_r, af_r, ae_r, ovf_r, unf_r;
    logic [WIDTH-1:0] rdata_r;
    logic [CW-1:0]    level_r;

    regb_fifo_lvl #(.WIDTH(WIDTH), .N(N), .AF_THR(AF_THR), .AE_THR(AE_THR), .FWFT(1)) dut_f (
        .clk(clk), .res(res), .shift_in(shift_in), .wdata(wdata), .full(full_f),
        .shift_out(shift_out), .rdata(rdata_f), .rvalid(rvalid_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .level(level_f),
        .overflow(ovf_f), .underflow(unf_f), .clr_err(clr_err)
    );

    regb_fifo_lvl #(.WIDTH(WIDTH), .N(N), .AF_THR(AF_THR), .AE_THR(AE_THR), .FWFT(0)) dut_r (
        .clk(clk), .res(res), .shift_in(shift_in), .wdata(wdata), .full(full_r),
        .shift_out(shift_out), .rdata(rdata_r), .rvalid(rvalid_r), .empty(empty_r),
        .almost_full(af_r), .almost_empty(ae_r), .level(level_r),
        .overflow(ovf_r), .underflow(unf_r), .clr_err(clr_err)
    );

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of stored words plus the error flags and the
    // registered-read output word.
    logic [WIDTH-1:0] q[$];
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;
    logic [WIDTH-1:0] m_rdata_r = '0;
    bit               m_rvalid_r = 1'b0;

    // Model update on each clock edge, cleared asynchronously by res.
    always @(posedge clk or posedge res) begin
        int sz;
        bit wok, rok;
        if (res) begin
            q.delete();
            m_ovf      = 1'b0;
            m_unf      = 1'b0;
            m_rdata_r  = '0;
            m_rvalid_r = 1'b0;
        end else begin
            sz  = q.size();
            wok = shift_in && (sz < N);
            rok = shift_out && (sz > 0);
            m_ovf = (m_ovf && !clr_err) || (shift_in && !wok);
            m_unf = (m_unf && !clr_err) || (shift_out && !rok);
            if (rok) begin
                m_rdata_r  = q.pop_front();
                m_rvalid_r = 1'b1;
            end else begin
                m_rvalid_r = 1'b0;
            end
            if (wok) q.push_back(wdata);
        end
    end

    // Compare both DUTs against the model on every falling edge.
    always @(negedge clk) begin
        int sz;
        if (started) begin
            sz = q.size();
            chk("level_f", 32'(level_f), 32'(sz));
            chk("level_r", 32'(level_r), 32'(sz));
            chk("empty_f", 32'(empty_f), 32'(sz == 0));
            chk("empty_r", 32'(empty_r), 32'(sz == 0));
            chk("full_f", 32'(full_f), 32'(sz == N));
            chk("full_r", 32'(full_r), 32'(sz == N));
            chk("af_f", 32'(af_f), 32'(sz >= AF_THR));
            chk("af_r", 32'(af_r), 32'(sz >= AF_THR));
            chk("ae_f", 32'(ae_f), 32'(sz <= AE_THR));
            chk("ae_r", 32'(ae_r), 32'(sz <= AE_THR));
            chk("ovf_f", 32'(ovf_f), 32'(m_ovf));
            chk("ovf_r", 32'(ovf_r), 32'(m_ovf));
            chk("unf_f", 32'(unf_f), 32'(m_unf));
            chk("unf_r", 32'(unf_r), 32'(m_unf));
            chk("rvalid_f", 32'(rvalid_f), 32'(sz > 0));
            if (sz > 0) chk("rdata_f", 32'(rdata_f), 32'(q[0]));
            chk("rvalid_r", 32'(rvalid_r), 32'(m_rvalid_r));
            chk("rdata_r", 32'(rdata_r), 32'(m_rdata_r));
        end
    end

    // One clock of stimulus; returns just after the active edge.
    task automatic step(input bit si, input bit so, input logic [WIDTH-1:0] wd, input bit ce);
        @(negedge clk);
        shift_in  = si;
        shift_out = so;
        wdata     = wd;
        clr_err   = ce;
        @(posedge clk);
        #1;
        $display("txn t=%0t si=%0d so=%0d wd=%h clr=%0d -> level=%0d rdata_f=%h rdata_r=%h rvalid_r=%0d ovf=%0d unf=%0d",
                 $time, si, so, wd, ce, level_f, rdata_f, rdata_r, rvalid_r, ovf_f, unf_f);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 res = 1'b1;
        #1;
        chk("rst_level", 32'(level_f), 32'd0);
        chk("rst_empty", 32'(empty_r), 32'd1);
        repeat (2) @(negedge clk);
        res = 1'b0;
        started = 1'b1;

        // Fill with 1..5, then one write too many.
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 16'(i), 0);
            if (i == 1) chk("fill1_ae", 32'(ae_f), 32'd1);
            if (i == 2) chk("fill2_ae", 32'(ae_r), 32'd0);
            if (i == 3) chk("fill3_af", 32'(af_f), 32'd0);
            if (i == 4) chk("fill4_af", 32'(af_r), 32'd1);
            if (i == 5) chk("fill5_full", 32'(full_f), 32'd1);
        end
        step(1, 0, 16'h0006, 0);
        chk("fill6_ovf", 32'(ovf_r), 32'd1);
        chk("fill6_level", 32'(level_r), 32'd5);

        // Drain five, then one read too many.
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 16'h0000, 0);
            if (i == 1) begin
                chk("drain1_rdata_r", 32'(rdata_r), 32'h0001);
                chk("drain1_rvalid_r", 32'(rvalid_r), 32'd1);
                chk("drain1_rdata_f", 32'(rdata_f), 32'h0002);
            end
            if (i == 5) chk("drain5_rdata_r", 32'(rdata_r), 32'h0005);
        end
        chk("drain_empty", 32'(empty_f), 32'd1);
        step(0, 1, 16'h0000, 0);
        chk("drain6_unf", 32'(unf_f), 32'd1);
        chk("drain6_rvalid_r", 32'(rvalid_r), 32'd0);
        step(0, 0, 16'h0000, 1);
        chk("clr_ovf", 32'(ovf_f), 32'd0);
        chk("clr_unf", 32'(unf_r), 32'd0);

        // Pointer wrap: write 3, read 3, then fill with A0..A4 and read back.
        for (int i = 0; i < 3; i++) step(1, 0, 16'($urandom), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 16'h0000, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 16'(16'h00A0 + i), 0);
        chk("wrap_full", 32'(full_r), 32'd1);
        chk("wrap_head_f", 32'(rdata_f), 32'h00A0);
        for (int i = 0; i < 5; i++) step(0, 1, 16'h0000, 0);
        chk("wrap_last_r", 32'(rdata_r), 32'h00A4);

        // Simultaneous push/pop at level 2, at full, and at empty.
        step(1, 0, 16'h0B01, 0);
        step(1, 0, 16'h0B02, 0);
        step(1, 1, 16'h0B03, 0);
        chk("sim2_level", 32'(level_f), 32'd2);
        chk("sim2_rdata_r", 32'(rdata_r), 32'h0B01);
        repeat (3) step(1, 0, 16'($urandom), 0);
        step(1, 1, 16'h0C00, 0);
        chk("simfull_level", 32'(level_r), 32'd4);
        chk("simfull_ovf", 32'(ovf_f), 32'd1);
        repeat (4) step(0, 1, 16'h0000, 0);
        step(0, 0, 16'h0000, 1);
        step(1, 1, 16'h0D00, 0);
        chk("simempty_level", 32'(level_f), 32'd1);
        chk("simempty_unf", 32'(unf_r), 32'd1);
        chk("simempty_ovf", 32'(ovf_r), 32'd0);

        // clr_err racing a rejected write: the set wins; clr_err alone clears.
        repeat (4) step(1, 0, 16'($urandom), 0);
        step(1, 0, 16'h0E00, 1);
        chk("clrrace_ovf", 32'(ovf_f), 32'd1);
        chk("clrrace_unf", 32'(unf_f), 32'd0);
        step(0, 0, 16'h0000, 1);
        chk("clralone_ovf", 32'(ovf_r), 32'd0);

        // Asynchronous reset between edges at level 3.
        repeat (2) step(0, 1, 16'h0000, 0);
        chk("prerst_level", 32'(level_f), 32'd3);
        #2;
        res       = 1'b1;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        clr_err   = 1'b0;
        #1;
        chk("arst_level_f", 32'(level_f), 32'd0);
        chk("arst_empty_r", 32'(empty_r), 32'd1);
        chk("arst_ae_f", 32'(ae_f), 32'd1);
        chk("arst_full_r", 32'(full_r), 32'd0);
        chk("arst_af_f", 32'(af_f), 32'd0);
        chk("arst_rvalid_f", 32'(rvalid_f), 32'd0);
        chk("arst_rdata_f", 32'(rdata_f), 32'd0);
        chk("arst_rdata_r", 32'(rdata_r), 32'd0);
        @(negedge clk);
        res = 1'b0;
        step(1, 0, 16'h1234, 0);
        chk("post_rdata_f", 32'(rdata_f), 32'h1234);
        step(0, 1, 16'h0000, 0);
        chk("post_rdata_r", 32'(rdata_r), 32'h1234);
        chk("post_rvalid_r", 32'(rvalid_r), 32'd1);

        // Randomized traffic with varying fill bias.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 200; i++) begin
                int pin;
                pin = (ph == 0) ? 70 : (ph == 1) ? 30 : 50;
                step($urandom_range(0, 99) < pin, $urandom_range(0, 99) < (100 - pin),
                     16'($urandom), $urandom_range(0, 15) == 0);
            end
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
